// File: rtl/alu_pkg.sv
// Shared constants and types for the shared-ALU arbiter: operand/control
// widths, the ALU code encoding and the sequencer state type.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int CODE_W = 3;

  // ALU code field; the arbiter passes it through without interpreting it.
  typedef enum logic [CODE_W-1:0] {
    CODE_ARITH = 3'b000,
    CODE_EQ    = 3'b001,
    CODE_LT    = 3'b010,
    CODE_GT    = 3'b011,
    CODE_CLX   = 3'b100,
    CODE_ADDI  = 3'b101,
    CODE_ADDIS = 3'b110
  } aluCode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arbState_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational grant logic for the two ALU requesters. A tie goes to the
// port that was not granted last (lastId); tying lastId high gives fixed
// priority to port 0.
module alu_arb_grant (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       lastId,
  input  logic       window,
  output logic [1:0] grant
);

  // One-hot grant, only inside the grant window.
  always_comb begin
    grant = 2'b00;
    if (window) begin
      if (valid0 && valid1) begin
        grant = lastId ? 2'b01 : 2'b10;
      end else if (valid0) begin
        grant = 2'b01;
      end else if (valid1) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer for the shared combinational ALU.
// Accepted requests drive registered ALU inputs; the result and zero flag
// are captured one cycle later and returned on a tagged valid/ready channel.
// Build option: define ALU_ARB_RR_EN for round-robin tie breaking; without
// it port 0 always wins ties and no pointer register exists.
module alu_share_arb #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int CODE_W = alu_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [CODE_W-1:0] r0_code,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [CODE_W-1:0] r1_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_operation,
  output logic [CODE_W-1:0] alu_code,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy
);

  import alu_pkg::*;

  arbState_t  stateQ;
  arbState_t  stateNext;
  logic       window;
  logic [1:0] grant;
  logic       accept;
  logic       accId;
  logic       lastId;
  logic       idQ;

  // Readys are held low while reset is asserted even though the state is IDLE.
  assign window = rst_n && ((stateQ == ST_IDLE) ||
                            ((stateQ == ST_RESP) && rsp_ready));

  alu_arb_grant uGrant (
    .valid0 (r0_valid),
    .valid1 (r1_valid),
    .lastId (lastId),
    .window (window),
    .grant  (grant)
  );

  assign r0_ready = grant[0];
  assign r1_ready = grant[1];
  assign accept   = |grant;
  assign accId    = grant[1];

`ifdef ALU_ARB_RR_EN
  logic rrPtr;

  // Remember the last granted port; reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= 1'b1;
    end else if (accept) begin
      rrPtr <= accId;
    end
  end

  assign lastId = rrPtr;
`else
  assign lastId = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // Next state: EXEC is always one cycle; RESP waits for the consumer.
  always_comb begin
    stateNext = stateQ;
    unique case (stateQ)
      ST_IDLE: if (accept) stateNext = ST_EXEC;
      ST_EXEC: stateNext = ST_RESP;
      ST_RESP: if (rsp_ready) stateNext = accept ? ST_EXEC : ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // ALU controls load only on acceptance and otherwise hold, since the
  // MOVN/MOVZ paths depend on the result staying put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= '0;
      alu_code      <= '0;
      idQ           <= 1'b0;
    end else if (accept) begin
      alu_a         <= accId ? r1_a    : r0_a;
      alu_b         <= accId ? r1_b    : r0_b;
      alu_operation <= accId ? r1_op   : r0_op;
      alu_code      <= accId ? r1_code : r0_code;
      idQ           <= accId;
    end
  end

  // Capture the ALU output at the close of EXEC; clear valid on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (stateQ == ST_EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end else if ((stateQ == ST_RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  assign rsp_id = idQ;
  assign busy   = (stateQ != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: a behavioural ALU drives alu_result/alu_zero,
// and each scenario task checks grants and responses against expectations
// derived from the request fields and the arbitration rule.
`timescale 1ns/1ps
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [5:0]  r0_op, r1_op;
  logic [2:0]  r0_code, r1_code;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [5:0]  alu_operation;
  logic [2:0]  alu_code;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_result;

  int errors = 0;
  int checks = 0;
  logic tbLast;

  logic [31:0] curA [2];
  logic [31:0] curB [2];
  logic [5:0]  curOp [2];
  logic [2:0]  curCode [2];

  logic [5:0] opTab [8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                            6'b100100, 6'b100101, 6'b100110, 6'b100111};

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
    int          cyc;
  } expT;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_code(r0_code),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_code(r1_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_code(alu_code), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Behavioural ALU: what the shared unit computes for a given operation.
  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op, input logic [2:0] code);
    int n;
    logic tgt;
    case (code)
      3'b000: begin
        case (op)
          6'b100010, 6'b100011: return a - b;
          6'b100100: return a & b;
          6'b100101: return a | b;
          6'b100110: return a ^ b;
          6'b100111: return ~(a | b);
          default:   return a + b;
        endcase
      end
      3'b001: return {31'd0, a == b};
      3'b010: return {31'd0, $signed(a) < $signed(b)};
      3'b011: return {31'd0, $signed(a) > $signed(b)};
      3'b100: begin
        n = 0;
        tgt = op[0];
        for (int i = 31; i >= 0; i--) begin
          if (a[i] == tgt) n++;
          else break;
        end
        return 32'(n);
      end
      3'b101, 3'b110: return a + b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = aluRef(alu_a, alu_b, alu_operation, alu_code);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic setReq(input int port, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] op, input logic [2:0] code);
    curA[port] = a; curB[port] = b; curOp[port] = op; curCode[port] = code;
    if (port == 0) begin
      r0_valid = 1'b1; r0_a = a; r0_b = b; r0_op = op; r0_code = code;
    end else begin
      r1_valid = 1'b1; r1_a = a; r1_b = b; r1_op = op; r1_code = code;
    end
  endtask

  task automatic rollReq(input int port);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    setReq(port, a, b, opTab[$urandom_range(0, 7)], 3'($urandom_range(0, 6)));
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b1;
    setReq(0, 32'h11, 32'h22, 6'b100001, 3'b000);
    setReq(1, 32'h33, 32'h44, 6'b100001, 3'b000);
    repeat (2) @(negedge clk);
    checks++; if ({r1_ready, r0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {r1_ready, r0_ready}); end
    checks++; if ({alu_a, alu_b, alu_operation, alu_code} !== '0) begin errors++; $display("FAIL reset_alu got=%h/%h/%b/%b exp=0", alu_a, alu_b, alu_operation, alu_code); end
    checks++; if ({rsp_valid, rsp_id, rsp_zero, busy} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b exp=0000", {rsp_valid, rsp_id, rsp_zero, busy}); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tbLast = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    setReq(0, 32'd5, 32'd3, 6'b100001, 3'b000); rsp_ready = 1'b1; #1;
    checks++; if ({r1_ready, r0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", {r1_ready, r0_ready}); end
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if ({busy, rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_exec got=%b exp=10", {busy, rsp_valid}); end
    checks++; if ({alu_a, alu_b, alu_operation, alu_code} !== {32'd5, 32'd3, 6'b100001, 3'b000}) begin errors++; $display("FAIL single_aluin got=%h/%h/%b/%b exp=5/3/100001/000", alu_a, alu_b, alu_operation, alu_code); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_zero} !== 3'b100) begin errors++; $display("FAIL single_rsp got=%b exp=100", {rsp_valid, rsp_id, rsp_zero}); end
    checks++; if (rsp_result !== 32'd8) begin errors++; $display("FAIL single_result got=%0d exp=8", rsp_result); end
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_idle got=%b exp=00", {rsp_valid, busy}); end
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL single_hold got=%0d exp=5", alu_a); end
    tbLast = 1'b0;
  endtask

  task automatic test_sub_zero;
    setReq(0, 32'd9, 32'd9, 6'b100010, 3'b000); rsp_ready = 1'b1;
    @(negedge clk); r0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_zero} !== 2'b11) begin errors++; $display("FAIL subzero_flags got=%b exp=11", {rsp_valid, rsp_zero}); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL subzero_result got=%h exp=0", rsp_result); end
    @(negedge clk);
    tbLast = 1'b0;
  endtask

  task automatic test_clz;
    setReq(0, 32'h0000_FFFF, $urandom, 6'b100000, 3'b100); rsp_ready = 1'b1;
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if ({alu_operation, alu_code} !== {6'b100000, 3'b100}) begin errors++; $display("FAIL clz_ctrl got=%b/%b exp=100000/100", alu_operation, alu_code); end
    checks++; if (alu_a !== 32'h0000_FFFF) begin errors++; $display("FAIL clz_opa got=%h exp=0000ffff", alu_a); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_zero} !== 2'b10 || rsp_result !== 32'd16) begin errors++; $display("FAIL clz_result got=%b/%0d exp=10/16", {rsp_valid, rsp_zero}, rsp_result); end
    @(negedge clk);
    tbLast = 1'b0;
  endtask

  task automatic test_back_to_back;
    expT expQ[$];
    expT e;
    int accepts = 0;
    int resps = 0;
    int lastAcc = 0;
    int reroll = -1;
    logic g;
    logic expG;
    rollReq(0); rollReq(1); rsp_ready = 1'b1; #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_spurious got=rsp id %0d exp=none", rsp_id);
        end else begin
          e = expQ.pop_front();
          checks++; if ({rsp_id, rsp_zero, rsp_result} !== {e.id, e.z, e.res}) begin errors++; $display("FAIL b2b_rsp got=%b/%b/%h exp=%b/%b/%h", rsp_id, rsp_zero, rsp_result, e.id, e.z, e.res); end
          checks++; if (cyc - e.cyc != 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", cyc - e.cyc); end
          resps++;
        end
      end
      if (r0_ready || r1_ready) begin
        g = r1_ready;
`ifdef ALU_ARB_RR_EN
        expG = ~tbLast;
`else
        expG = 1'b0;
`endif
        checks++; if ({r1_ready, r0_ready} !== (expG ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant got=%b exp=%b", {r1_ready, r0_ready}, expG ? 2'b10 : 2'b01); end
        if (accepts > 0) begin
          checks++; if (cyc - lastAcc != 2) begin errors++; $display("FAIL b2b_spacing got=%0d exp=2", cyc - lastAcc); end
        end
        e.id = g;
        e.res = aluRef(curA[g], curB[g], curOp[g], curCode[g]);
        e.z = (e.res == 32'd0);
        e.cyc = cyc;
        expQ.push_back(e);
        tbLast = g; lastAcc = cyc; accepts++; reroll = int'(g);
      end
      @(negedge clk);
      if (accepts >= 8) begin
        r0_valid = 1'b0; r1_valid = 1'b0;
      end else if (reroll >= 0) begin
        rollReq(reroll);
      end
      reroll = -1;
      #1;
      if (accepts >= 8 && expQ.size() == 0 && !rsp_valid) break;
    end
    checks++; if (accepts != 8 || resps != 8) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", accepts, resps); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    setReq(1, 32'd7, 32'd7, 6'b100001, 3'b001); #1;
    checks++; if ({r1_ready, r0_ready} !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", {r1_ready, r0_ready}); end
    @(negedge clk);
    setReq(1, 32'd1, 32'd2, 6'b000000, 3'b010); #1;
    checks++; if ({r1_ready, r0_ready, busy} !== 3'b001) begin errors++; $display("FAIL bp_exec got=%b exp=001", {r1_ready, r0_ready, busy}); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) setReq(0, 32'd3, 32'd4, 6'b100001, 3'b000);
      if (i == 3) r0_valid = 1'b0;
      #1;
      checks++; if ({rsp_valid, rsp_id, rsp_zero, rsp_result} !== {3'b110, 32'd1}) begin errors++; $display("FAIL bp_hold got=%b/%h exp=110/1", {rsp_valid, rsp_id, rsp_zero}, rsp_result); end
      checks++; if ({r1_ready, r0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready got=%b exp=00", {r1_ready, r0_ready}); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; #1;
    checks++; if ({r1_ready, r0_ready} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", {r1_ready, r0_ready}); end
    @(negedge clk); r1_valid = 1'b0; #1;
    checks++; if ({rsp_valid, busy, alu_a, alu_code} !== {2'b01, 32'd1, 3'b010}) begin errors++; $display("FAIL bp_next got=%b/%h/%b exp=01/1/010", {rsp_valid, busy}, alu_a, alu_code); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, 32'd1}) begin errors++; $display("FAIL bp_second got=%b/%h exp=11/1", {rsp_valid, rsp_id}, rsp_result); end
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_idle got=%b exp=00", {rsp_valid, busy}); end
    tbLast = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] expR;
    rsp_ready = 1'b1;
    setReq(0, $urandom, $urandom, 6'b100001, 3'b000);
    @(negedge clk); r0_valid = 1'b0;
    setReq(1, 32'd1, 32'd1, 6'b100001, 3'b000); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_exec got=%b exp=1", busy); end
    rst_n = 1'b0; #1;
    checks++; if ({busy, rsp_valid, r1_ready, r0_ready} !== 4'b0000 || alu_a !== 32'd0) begin errors++; $display("FAIL rmid_reset got=%b/%h exp=0000/0", {busy, rsp_valid, r1_ready, r0_ready}, alu_a); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_result} !== 33'd0) begin errors++; $display("FAIL rmid_norsp got=%b/%h exp=0/0", rsp_valid, rsp_result); end
    rst_n = 1'b1; tbLast = 1'b1;
    setReq(0, 32'd100, 32'd23, 6'b100011, 3'b000);
    setReq(1, 32'd40, 32'd2, 6'b100001, 3'b101); #1;
    checks++; if ({r1_ready, r0_ready} !== 2'b01) begin errors++; $display("FAIL rmid_tie got=%b exp=01", {r1_ready, r0_ready}); end
    @(negedge clk); r0_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd77}) begin errors++; $display("FAIL rmid_after got=%b/%0d exp=10/77", {rsp_valid, rsp_id}, rsp_result); end
    checks++; if ({r1_ready, r0_ready} !== 2'b10) begin errors++; $display("FAIL rmid_b2b got=%b exp=10", {r1_ready, r0_ready}); end
    expR = 32'd42;
    @(negedge clk); r1_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, expR}) begin errors++; $display("FAIL rmid_second got=%b/%0d exp=11/%0d", {rsp_valid, rsp_id}, rsp_result, expR); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", busy); end
  endtask

  initial begin
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = '0; r0_code = '0;
    r1_a = '0; r1_b = '0; r1_op = '0; r1_code = '0;
    rsp_ready = 1'b0; rst_n = 1'b0; tbLast = 1'b1;
    test_reset;
    test_single;
    test_sub_zero;
    test_clz;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer for the shared 32-bit combinational ALU. The block accepts operation requests from two clients (port 0: execute stage, port 1: branch/compare unit) and grants one at a time. It drives the ALU operand/control inputs from registers, captures the result and zero flag one cycle later, and returns them on a single tagged response channel with valid/ready flow control.

## Interface
- `DATA_W`, 32, operand/result width
- `OP_W`, 6, function-code width
- `CODE_W`, 3, ALU code width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `r0_valid` in 1: request 0 valid
- `r0_ready` out 1: request 0 accepted this cycle
- `r0_a` / `r0_b` in DATA_W: request 0 operands
- `r0_op` in OP_W, `r0_code` in CODE_W: request 0 function code and ALU code
- `r1_valid`, `r1_ready`, `r1_a`, `r1_b`, `r1_op`, `r1_code`: same for request 1
- `alu_a` / `alu_b` out DATA_W: ALU operands (registered)
- `alu_operation` out OP_W, `alu_code` out CODE_W: ALU controls (registered)
- `alu_result` in DATA_W, `alu_zero` in 1: ALU outputs
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: consumer accepts response
- `rsp_id` out 1: requester index of response
- `rsp_result` out DATA_W, `rsp_zero` out 1: captured ALU result and zero flag
- `busy` out 1: state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Grant window: state IDLE, or state RESP with `rsp_ready`=1.
  - In the grant window, at most one `rX_ready` is high, computed combinationally from `rX_valid` and the arbitration rule.
  - Outside the window, both readys are 0.
- Acceptance (`rX_valid`&&`rX_ready`) at an edge:
  - Loads `alu_a`, `alu_b`, `alu_operation` and `alu_code` from that requester.
  - Loads the id register.
  - Moves to EXEC.
- EXEC always lasts exactly one cycle. At its closing edge, `rsp_result`←`alu_result`, `rsp_zero`←`alu_zero`, `rsp_valid`←1, and the state moves to RESP.
- RESP: response fields are held stable while `rsp_valid`=1 and `rsp_ready`=0.
  - `rsp_ready`=1 with a new acceptance: go to EXEC (back-to-back).
  - `rsp_ready`=1 without an acceptance: go to IDLE, `rsp_valid`←0.
- ALU control registers hold their last value when idle, because the ALU's MOVN/MOVZ paths retain Result. They are never cleared except by reset.
- Requests must hold their fields stable while `rX_valid`=1 and not accepted. Dropping valid before acceptance is allowed; no request is then issued.
- The block does not interpret op/code. CLO/CLZ, shifts and compares all pass through unchanged.

## Timing
- Reset values: `r0_ready`=`r1_ready`=0 during reset, all `alu_*`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `busy`=0, round-robin pointer=1 (so port 0 wins the first tie).
- Latency: acceptance at edge k gives `rsp_valid`=1 after edge k+1.
- Throughput: one operation per 2 cycles when `rsp_ready` is held high.
- Simultaneous valid: resolved by the arbitration rule (see Configuration). The losing requester waits; its valid must persist.
- `rsp_ready` high while not in RESP: ignored.
- Reset asserted mid-operation: everything returns to reset values immediately and the in-flight operation is discarded without a response.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer records the last granted id and updates on each acceptance.
  - On a tie, the port other than the last granted one wins.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. The pointer register is not built.

## Structure
- Shared package `alu_pkg` holds:
  - `DATA_W`, `OP_W`, `CODE_W` constants.
  - The ALU code enum (000 arithmetic, 001 eq, 010 lt, 011 gt, 100 clo/clz, 101 addi, 110 addi signed).
  - The FSM state typedef.
- One sub-module is natural: `alu_arb_grant`, the combinational grant logic. Inputs are the valids, pointer and window; outputs are the one-hot grant.

## Test plan
- Single request, port 0, a=5, b=3, op=100001, code=000, `rsp_ready`=1 → `rsp_valid` 2 edges after valid, `rsp_result`=8, `rsp_id`=0, then IDLE.
- Both valid every cycle, `rsp_ready`=1, RR build → grants alternate 0,1,0,1, one response per 2 cycles. Fixed build → port 0 always granted, port 1 starves.
- Backpressure: `rsp_ready`=0 for 4 cycles after response (a=7, b=7, code=001) → `rsp_result`=1 and `rsp_zero`=0 held stable, both readys stay 0, and port 1 accepted the cycle `rsp_ready` rises.
- Subtract to zero (a=9, b=9, op=100010, code=000) → `rsp_result`=0, `rsp_zero`=1.
- `rst_n` low during EXEC → next cycle all outputs at reset values, no response emitted, and a new request after release completes normally.
- CLZ pass-through (a=0x0000_FFFF, op=100000, code=100) → `alu_operation`=100000 and `alu_code`=100 while in EXEC, `rsp_result` equals the ALU output sampled at EXEC close.
